// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Read hits return data in the same cycle; misses and stores stall until the backing memory acks.
`timescale 1ns/1ps
module data_cache #(
   parameter int DATA_WIDTH  = 32,
   parameter int SETS        = 64,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            AddrMode,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] WD,
   output logic [DATA_WIDTH-1:0] RD,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   localparam int IDX_W   = $clog2(SETS);
   localparam int WO_W    = $clog2(BLOCK_WORDS);
   localparam int TAG_LSB = 2 + WO_W + IDX_W;
   localparam int TAG_W   = DATA_WIDTH - TAG_LSB;
   localparam logic [WO_W-1:0] LAST_BEAT = WO_W'(BLOCK_WORDS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REFILL = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [WO_W-1:0]       beat_q, beat_d;
   logic [SETS-1:0]       valid_q;
   logic [TAG_W-1:0]      tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS*BLOCK_WORDS];

   logic [DATA_WIDTH-1:0] addr_al;
   logic [WO_W-1:0]       word_idx;
   logic [IDX_W-1:0]      set_idx;
   logic [TAG_W-1:0]      tag;
   logic                  hit;
   logic [DATA_WIDTH-1:0] cur_word, load_val, st_data;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [3:0]            st_strb;
   logic                  fill_en, wr_hit_en;

   // Half and word accesses silently drop the low offset bits; there is no misalignment trap.
   always_comb begin
      addr_al = A;
      case (AddrMode[1:0])
         2'b01:   addr_al[0]   = 1'b0;
         2'b10:   addr_al[1:0] = 2'b00;
         default: ;
      endcase
   end

   assign word_idx = addr_al[2 +: WO_W];
   assign set_idx  = addr_al[2 + WO_W +: IDX_W];
   assign tag      = addr_al[TAG_LSB +: TAG_W];
   assign hit      = valid_q[set_idx] && (tag_q[set_idx] == tag);
   assign cur_word = data_q[{set_idx, word_idx}];

   always_comb begin
      case (addr_al[1:0])
         2'd0:    byte_sel = cur_word[7:0];
         2'd1:    byte_sel = cur_word[15:8];
         2'd2:    byte_sel = cur_word[23:16];
         default: byte_sel = cur_word[31:24];
      endcase
      half_sel = addr_al[1] ? cur_word[31:16] : cur_word[15:0];
      case (AddrMode[1:0])
         2'b00:   load_val = {{(DATA_WIDTH-8){byte_sel[7] & ~AddrMode[2]}}, byte_sel};
         2'b01:   load_val = {{(DATA_WIDTH-16){half_sel[15] & ~AddrMode[2]}}, half_sel};
         default: load_val = cur_word;
      endcase
   end

   always_comb begin
      case (AddrMode[1:0])
         2'b00: begin
            st_strb = 4'b0001 << addr_al[1:0];
            st_data = {4{WD[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << {addr_al[1], 1'b0};
            st_data = {2{WD[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = WD;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
      RD        = '0;
      fill_en   = 1'b0;
      wr_hit_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MemWrite) begin
               stall   = 1'b1;
               state_d = S_WRITE;
            end else if (MemRead) begin
               if (hit) begin
                  RD = load_val;
               end else begin
                  stall   = 1'b1;
                  beat_d  = '0;
                  state_d = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {tag, set_idx, beat_q, 2'b00};
            if (mem_ack) begin
               fill_en = 1'b1;
               beat_d  = beat_q + WO_W'(1);
               if (beat_q == LAST_BEAT) state_d = S_RESP;
            end
         end
         S_WRITE: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {addr_al[DATA_WIDTH-1:2], 2'b00};
            mem_wdata = st_data;
            mem_wstrb = st_strb;
            if (mem_ack) begin
               wr_hit_en = hit;
               state_d   = S_RESP;
            end
         end
         default: begin
            if (MemRead && !MemWrite) RD = load_val;
            state_d = S_IDLE;
         end
      endcase
      // Reset quiets the outputs immediately so a late ack cannot land in the arrays.
      if (rst) begin
         stall     = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_wstrb = 4'b0000;
         mem_wdata = '0;
         RD        = '0;
         fill_en   = 1'b0;
         wr_hit_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (fill_en && beat_q == LAST_BEAT) valid_q[set_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[{set_idx, beat_q}] <= mem_rdata;
         if (beat_q == LAST_BEAT) tag_q[set_idx] <= tag;
      end
      if (wr_hit_en) begin
         for (int b = 0; b < 4; b++) begin
            if (st_strb[b]) data_q[{set_idx, word_idx}][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a negedge-driven backing memory model logs every beat,
// and each scenario task checks beats, stall behaviour and load results against hand-computed values.
`timescale 1ns/1ps
module tb_data_cache;

   localparam logic [2:0] M_B  = 3'b000;
   localparam logic [2:0] M_H  = 3'b001;
   localparam logic [2:0] M_W  = 3'b010;
   localparam logic [2:0] M_BU = 3'b100;
   localparam logic [2:0] M_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  AddrMode = 3'b010;
   logic [31:0] A = '0, WD = '0;
   logic [31:0] RD;
   logic        stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:1023];
   logic [31:0] log_addr  [$];
   logic        log_we    [$];
   logic [3:0]  log_strb  [$];
   logic [31:0] log_wdata [$];

   data_cache dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .AddrMode(AddrMode),
      .A(A), .WD(WD), .RD(RD), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // Backing memory: answers each request with a one-cycle ack, one idle cycle between beats.
   always @(negedge clk) begin
      if (rst) begin
         mem_ack = 1'b0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req) begin
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_strb.push_back(mem_wstrb);
         log_wdata.push_back(mem_wdata);
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
         mem_rdata = mem[mem_addr[11:2]];
         mem_ack = 1'b1;
      end
   end

   task automatic do_access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                            input logic [2:0] mode, input logic [31:0] wd,
                            output logic [31:0] rd, output int stalls);
      @(negedge clk);
      MemRead = rd_en; MemWrite = wr_en; A = addr; AddrMode = mode; WD = wd;
      stalls = 0;
      #1;
      for (int i = 0; i < 64; i++) begin
         if (!stall) break;
         stalls++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL access_timeout: addr %h stall still %b, required 0", addr, stall);
      end
      rd = RD;
      @(posedge clk);
      #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0 || RD !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: stall=%b req=%b we=%b strb=%b RD=%h, required all zero",
                  stall, mem_req, mem_we, mem_wstrb, RD);
      end
   endtask

   task automatic test_refill_hit();
      logic [31:0] rd; int st; int b0;
      mem[10'h40] = 32'h11; mem[10'h41] = 32'h22; mem[10'h42] = 32'h33; mem[10'h43] = 32'h44;
      b0 = log_addr.size();
      do_access(1'b1, 1'b0, 32'h100, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h11 || st == 0) begin
         failures++;
         $display("FAIL refill_rd: RD=%h stalls=%0d, required RD=00000011 with stall", rd, st);
      end
      checks++;
      if (log_addr.size() - b0 != 4) begin
         failures++;
         $display("FAIL refill_beats: got %0d beats, required 4", log_addr.size() - b0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[b0+i] !== 32'h100 + 32'(4*i) || log_we[b0+i] !== 1'b0) begin
               failures++;
               $display("FAIL refill_beat%0d: addr=%h we=%b, required addr=%h we=0",
                        i, log_addr[b0+i], log_we[b0+i], 32'h100 + 32'(4*i));
            end
         end
      end
      b0 = log_addr.size();
      do_access(1'b1, 1'b0, 32'h108, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h33 || st != 0 || log_addr.size() != b0) begin
         failures++;
         $display("FAIL hit_108: RD=%h stalls=%0d beats=%0d, required RD=00000033 no stall no beats",
                  rd, st, log_addr.size() - b0);
      end
   endtask

   task automatic test_store_hit();
      logic [31:0] rd; int st; int b0;
      b0 = log_addr.size();
      do_access(1'b0, 1'b1, 32'h100, M_W, 32'h11223344, rd, st);
      checks++;
      if (log_addr.size() - b0 != 1 || log_addr[$] !== 32'h100 || log_we[$] !== 1'b1 ||
          log_strb[$] !== 4'b1111 || log_wdata[$] !== 32'h11223344 || st == 0) begin
         failures++;
         $display("FAIL sw_100: beats=%0d addr=%h we=%b strb=%b wdata=%h, required 1 beat 00000100 1 1111 11223344",
                  log_addr.size() - b0, log_addr[$], log_we[$], log_strb[$], log_wdata[$]);
      end
      b0 = log_addr.size();
      do_access(1'b0, 1'b1, 32'h101, M_B, 32'h000000AB, rd, st);
      checks++;
      if (log_addr.size() - b0 != 1 || log_addr[$] !== 32'h100 || log_strb[$] !== 4'b0010 ||
          log_wdata[$][15:8] !== 8'hAB) begin
         failures++;
         $display("FAIL sb_101: beats=%0d addr=%h strb=%b wdata=%h, required 1 beat 00000100 0010 lane1=AB",
                  log_addr.size() - b0, log_addr[$], log_strb[$], log_wdata[$]);
      end
      do_access(1'b1, 1'b0, 32'h101, M_BU, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h000000AB || st != 0) begin
         failures++;
         $display("FAIL lbu_101: RD=%h stalls=%0d, required 000000ab no stall", rd, st);
      end
      do_access(1'b1, 1'b0, 32'h100, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h1122AB44 || st != 0) begin
         failures++;
         $display("FAIL lw_merged: RD=%h stalls=%0d, required 1122ab44 no stall", rd, st);
      end
   endtask

   task automatic test_write_miss();
      logic [31:0] rd; int st; int b0;
      b0 = log_addr.size();
      do_access(1'b0, 1'b1, 32'h400, M_W, 32'hDEADBEEF, rd, st);
      checks++;
      if (log_addr.size() - b0 != 1 || log_addr[$] !== 32'h400 || log_we[$] !== 1'b1 ||
          log_strb[$] !== 4'b1111 || log_wdata[$] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL sw_400: beats=%0d addr=%h we=%b strb=%b wdata=%h, required 1 beat 00000400 1 1111 deadbeef",
                  log_addr.size() - b0, log_addr[$], log_we[$], log_strb[$], log_wdata[$]);
      end
      b0 = log_addr.size();
      do_access(1'b1, 1'b0, 32'h400, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'hDEADBEEF || st == 0 || log_addr.size() - b0 != 4 || log_addr[b0] !== 32'h400) begin
         failures++;
         $display("FAIL lw_400_no_alloc: RD=%h stalls=%0d beats=%0d, required deadbeef after a 4-beat refill",
                  rd, st, log_addr.size() - b0);
      end
   endtask

   task automatic test_extension();
      logic [31:0] rd; int st;
      logic [31:0] v_addr [8];
      logic [2:0]  v_mode [8];
      logic [31:0] v_exp  [8];
      mem[10'h80] = 32'h0000F080;
      mem[10'h81] = 32'h80017F00;
      v_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h205, 32'h207, 32'h207, 32'h203};
      v_mode = '{M_B, M_BU, M_H, M_HU, M_B, M_H, M_W, M_HU};
      v_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080, 32'h0000F080,
                 32'h0000007F, 32'hFFFF8001, 32'h80017F00, 32'h00000000};
      do_access(1'b1, 1'b0, 32'h200, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h0000F080 || st == 0) begin
         failures++;
         $display("FAIL ext_fill: RD=%h stalls=%0d, required 0000f080 after a miss", rd, st);
      end
      for (int i = 0; i < 8; i++) begin
         do_access(1'b1, 1'b0, v_addr[i], v_mode[i], 32'h0, rd, st);
         checks++;
         if (rd !== v_exp[i] || st != 0) begin
            failures++;
            $display("FAIL ext_%0d: addr=%h mode=%b RD=%h stalls=%0d, required %h no stall",
                     i, v_addr[i], v_mode[i], rd, st, v_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; int st; int b0;
      b0 = log_addr.size();
      do_access(1'b1, 1'b1, 32'h204, M_W, 32'h12345678, rd, st);
      checks++;
      if (log_addr.size() - b0 != 1 || log_we[$] !== 1'b1 || log_addr[$] !== 32'h204) begin
         failures++;
         $display("FAIL rdwr_as_write: beats=%0d we=%b addr=%h, required 1 write beat to 00000204",
                  log_addr.size() - b0, log_we[$], log_addr[$]);
      end
      do_access(1'b1, 1'b0, 32'h204, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h12345678 || st != 0) begin
         failures++;
         $display("FAIL rdwr_readback: RD=%h stalls=%0d, required 12345678 no stall", rd, st);
      end
   endtask

   task automatic test_aliasing();
      logic [31:0] rd; int st; int b0;
      mem[10'h140] = 32'h00000055;
      b0 = log_addr.size();
      do_access(1'b1, 1'b0, 32'h500, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h55 || st == 0 || log_addr.size() - b0 != 4 || log_addr[b0] !== 32'h500) begin
         failures++;
         $display("FAIL alias_500: RD=%h stalls=%0d beats=%0d, required 00000055 after 4-beat refill",
                  rd, st, log_addr.size() - b0);
      end
      b0 = log_addr.size();
      do_access(1'b1, 1'b0, 32'h100, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h1122AB44 || st == 0 || log_addr.size() - b0 != 4 || log_addr[b0] !== 32'h100) begin
         failures++;
         $display("FAIL alias_evict_100: RD=%h stalls=%0d beats=%0d, required 1122ab44 after 4-beat refill",
                  rd, st, log_addr.size() - b0);
      end
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] rd; int st; int b0;
      mem[10'hC0] = 32'h330000A0; mem[10'hC1] = 32'h330000A1;
      mem[10'hC2] = 32'h330000A2; mem[10'hC3] = 32'h330000A3;
      b0 = log_addr.size();
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; A = 32'h300; AddrMode = M_W;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (log_addr.size() >= b0 + 2) break;
      end
      checks++;
      if (log_addr.size() != b0 + 2) begin
         failures++;
         $display("FAIL midrefill_beats: got %0d beats, required 2", log_addr.size() - b0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      MemRead = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL during_reset: stall=%b req=%b, required 0 0", stall, mem_req);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || RD !== 32'h0) begin
         failures++;
         $display("FAIL after_reset: stall=%b req=%b RD=%h, required 0 0 00000000", stall, mem_req, RD);
      end
      b0 = log_addr.size();
      do_access(1'b1, 1'b0, 32'h300, M_W, 32'h0, rd, st);
      checks++;
      if (rd !== 32'h330000A0 || st == 0 || log_addr.size() - b0 != 4) begin
         failures++;
         $display("FAIL reload_300: RD=%h stalls=%0d beats=%0d, required 330000a0 after 4-beat refill",
                  rd, st, log_addr.size() - b0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[b0+i] !== 32'h300 + 32'(4*i)) begin
               failures++;
               $display("FAIL reload_beat%0d: addr=%h, required %h", i, log_addr[b0+i], 32'h300 + 32'(4*i));
            end
         end
      end
      // The earlier line at 0x100 must also have been invalidated by the reset.
      do_access(1'b1, 1'b0, 32'h100, M_W, 32'h0, rd, st);
      checks++;
      if (st == 0 || rd !== 32'h1122AB44) begin
         failures++;
         $display("FAIL reset_invalidates: RD=%h stalls=%0d, required 1122ab44 after a miss", rd, st);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      test_reset();
      test_refill_hit();
      test_store_hit();
      test_write_miss();
      test_extension();
      test_back_to_back();
      test_aliasing();
      test_reset_mid_refill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache that serves the pipeline's memory stage.
- Sits between the memory-stage address/data signals (ALU result as address, store data, AddrMode) and a word-wide backing memory with a req/ack handshake.
- Returns sign- or zero-extended load data in the same cycle on a read hit.
- Asserts stall to the hazard logic for misses and stores until the backing transaction completes.

Parameters:
DATA_WIDTH, 32, CPU and memory data/address width.
SETS, 64, number of cache lines (power of 2).
BLOCK_WORDS, 4, words per line (power of 2).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
MemRead  input  1  load request this cycle
MemWrite  input  1  store request this cycle
AddrMode  input  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
A  input  32  byte address
WD  input  32  store data, right-aligned
RD  output  32  load result, extended per AddrMode
stall  output  1  holds the pipeline while high
mem_req  output  1  backing memory request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  word-aligned backing address
mem_wdata  output  32  store data shifted to byte lane
mem_wstrb  output  4  byte enables for writes
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  one-cycle completion pulse for the current request

Behaviour:
- Address split:
  - A[1:0] is the byte offset.
  - Next log2(BLOCK_WORDS) bits are the word index.
  - Next log2(SETS) bits are the set index.
  - Remaining bits are the tag.
  - Defaults give 2/2/6/22.
- Alignment: half forces A[0]=0 and word forces A[1:0]=0. There is no misalignment trap.
- Per-line storage: a valid bit, a tag, and BLOCK_WORDS data words.
- Simultaneous MemRead and MemWrite: treated as a write.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE:
  - Read hit (valid && tag match): RD driven combinationally from the line, stall=0, stay in IDLE. Zero added latency.
  - Read miss: stall=1 combinationally, beat counter cleared, next state REFILL.
  - Write (hit or miss): stall=1, next state WRITE.
  - No request: stall=0, RD=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = line base + beat*4.
  - On mem_ack: store mem_rdata into word[beat] and increment beat.
  - On the ack of beat BLOCK_WORDS-1: set valid, write the tag, next state RESP.
  - Beats are issued strictly in order from 0. No critical-word-first.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = {A[31:2],2'b00}.
  - mem_wstrb: byte 0001<<A[1:0]; half 0011<<{A[1],1'b0}; word 1111.
  - mem_wdata: WD replicated or shifted into the selected lanes.
  - On mem_ack: if the line hits, merge the enabled bytes into the cached word. Next state RESP.
  - A write miss leaves the cache unchanged.
- RESP:
  - stall=0 and mem_req=0.
  - If the request was a read, RD comes from the now-valid line.
  - Next state is IDLE unconditionally. The pipeline advances at the end of this cycle, so the request is not re-evaluated.
- stall is high in REFILL and WRITE regardless of mem_ack.
- Outside REFILL and WRITE: mem_req=0, mem_we=0, mem_wstrb=0.
- Inputs A, WD, AddrMode and MemRead/MemWrite are guaranteed stable while stall=1, because the pipeline is frozen. The cache does not latch them.
- Load extension: byte/half select uses the offset bits. Modes 000/001 sign-extend; 100/101 zero-extend.
- Reset, in any state including mid-refill:
  - Next state IDLE.
  - All valid bits cleared, beat counter 0.
  - mem_req=0, stall=0, RD=0.
  - Data and tag arrays need not be cleared.
  - A mem_ack arriving after reset is ignored.
- mem_ack in IDLE or RESP: ignored.

Test Plan:
1. After reset, load word 0x100 with backing mem[0x100..0x10C] = 0x11,0x22,0x33,0x44 -> stall high; 4 read beats at 0x100,0x104,0x108,0x10C; RESP cycle with RD=0x11 and stall=0. A following load of 0x108 hits with RD=0x33 and no stall.
2. Line at 0x100 cached holding 0x11223344; sb 0xAB to 0x101 -> one write beat, mem_wstrb=0010, mem_wdata[15:8]=0xAB. Then lbu 0x101 hits with RD=0x000000AB, and lw 0x100 returns 0x1122AB44.
3. sw 0xDEADBEEF to uncached 0x400 -> one write beat, then RESP. The following lw 0x400 misses and refills (no write allocate).
4. Cached word 0x0000F080 at 0x200: lb 0x200 -> RD=0xFFFFFF80; lbu 0x200 -> 0x00000080; lh 0x200 -> 0xFFFFF080; lhu 0x200 -> 0x0000F080.
5. Aliasing: load 0x100, then load 0x500 (same set, different tag) -> second load misses and evicts the first line. A reload of 0x100 misses again.
6. Assert rst after the 2nd refill beat ack -> next cycle IDLE, stall=0, mem_req=0. Reload of the same address misses and performs a full 4-beat refill.
